pad_ctrl: RTL and testbench

Padding sequencer that sits directly upstream of `pktmux`. It counts 64-bit message words into 16-word (1024-bit) blocks and accumulates the message length in bits. After the last data word it drives `pad_pkt`, `zero_pkt` and `mgln_pkt` so that `pktmux` emits one pad word, then zero words, then the length word in the last slot of a block. Valid/ready handshakes on both sides let data stall without losing alignment.

---
 rtl/pad_ctrl.sv | 98 +++++++++
 tb/tb_pad_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pad_ctrl.sv
// Padding sequencer for pktmux: counts message words into BLK_WORDS-word blocks,
// tracks length in bits, then steers pktmux through pad, zero and length words.
module pad_ctrl #(
  parameter int BLK_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  input  logic        pkt_last,
  output logic        pkt_ready,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        pad_pkt,
  output logic        zero_pkt,
  output logic        mgln_pkt,
  output logic [63:0] msg_len,
  output logic        blk_done,
  output logic        msg_done
);

  localparam int IW = $clog2(BLK_WORDS);
  localparam logic [IW-1:0] IDX_PRE_LEN = IW'(BLK_WORDS - 2);
  localparam logic [IW-1:0] IDX_LAST    = IW'(BLK_WORDS - 1);

  typedef enum logic [1:0] {
    S_DATA,
    S_PAD,
    S_ZERO,
    S_LEN
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] widx;
  logic          xfer;

  assign xfer = o_valid && o_ready;

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through the block leaves a variable unassigned (no latches).
  always_comb begin
    state_nxt = state;
    o_valid   = 1'b0;
    pkt_ready = 1'b0;
    pad_pkt   = 1'b0;
    zero_pkt  = 1'b0;
    mgln_pkt  = 1'b0;
    unique case (state)
      S_DATA: begin
        o_valid   = pkt_valid;
        pkt_ready = o_ready;
        if (xfer && pkt_last) state_nxt = S_PAD;
      end
      S_PAD: begin
        o_valid = 1'b1;
        pad_pkt = 1'b1;
        if (xfer) state_nxt = (widx == IDX_PRE_LEN) ? S_LEN : S_ZERO;
      end
      S_ZERO: begin
        o_valid  = 1'b1;
        zero_pkt = 1'b1;
        if (xfer && widx == IDX_PRE_LEN) state_nxt = S_LEN;
      end
      S_LEN: begin
        o_valid  = 1'b1;
        mgln_pkt = 1'b1;
        if (xfer) state_nxt = S_DATA;
      end
      default: state_nxt = S_DATA;
    endcase
    // Handshakes are held off for the whole time reset is asserted.
    if (rst) begin
      o_valid   = 1'b0;
      pkt_ready = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_DATA;
      widx     <= '0;
      msg_len  <= '0;
      blk_done <= 1'b0;
      msg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      blk_done <= xfer && (widx == IDX_LAST);
      msg_done <= xfer && (state == S_LEN);
      if (xfer) begin
        widx <= widx + IW'(1);
        if (state == S_DATA)     msg_len <= msg_len + 64'd64;
        else if (state == S_LEN) msg_len <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pad_ctrl.sv
// Self-checking bench for pad_ctrl: directed scenarios plus randomized handshakes,
// checked against a per-message word-sequence model derived from block arithmetic.
module tb_pad_ctrl;

  localparam int BW = 16;
  localparam int K_DATA = 0, K_PAD = 1, K_ZERO = 2, K_LEN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid, pkt_last, pkt_ready;
  logic        o_valid, o_ready;
  logic        pad_pkt, zero_pkt, mgln_pkt;
  logic [63:0] msg_len;
  logic        blk_done, msg_done;

  int passed = 0;
  int total  = 0;

  pad_ctrl #(.BLK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
    .o_valid(o_valid), .o_ready(o_ready),
    .pad_pkt(pad_pkt), .zero_pkt(zero_pkt), .mgln_pkt(mgln_pkt),
    .msg_len(msg_len), .blk_done(blk_done), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Words emitted for an n-word message: data, pad, zeros, then length in the
  // last slot of a block, i.e. n+2 rounded up to a whole number of blocks.
  function automatic int msg_words(input int n);
    return ((n + 2 + BW - 1) / BW) * BW;
  endfunction

  function automatic int word_kind(input int n, input int pos);
    if (pos < n)                  return K_DATA;
    if (pos == n)                 return K_PAD;
    if (pos == msg_words(n) - 1)  return K_LEN;
    return K_ZERO;
  endfunction

  // mode 0: always valid/ready; 1: random valid and ready; 2: ready toggles
  // outside data. stop_at >= 0 abandons the message after that many transfers.
  task automatic run_msg(input int n, input int mode, input int stop_at);
    int pos = 0, cyc = 0, nblk = 0, nmsg = 0;
    int tw = msg_words(n);
    int kind;
    logic rdy, vld, xfer, exp_ov, tog = 1'b0;
    while (pos < tw && pos != stop_at) begin
      if (cyc > 4000) begin
        check("timeout", 64'(pos), 64'(tw));
        return;
      end
      cyc++;
      kind = word_kind(n, pos);
      tog  = ~tog;
      case (mode)
        1:       begin rdy = 1'($urandom_range(0, 1)); vld = 1'($urandom_range(0, 1)); end
        2:       begin rdy = (kind == K_DATA) ? 1'b1 : tog; vld = 1'b1; end
        default: begin rdy = 1'b1; vld = 1'b1; end
      endcase
      pkt_valid = vld;
      pkt_last  = (kind == K_DATA) ? (pos == n - 1) : 1'($urandom_range(0, 1));
      o_ready   = rdy;
      #1;
      exp_ov = (kind == K_DATA) ? vld : 1'b1;
      xfer   = exp_ov && rdy;
      check("o_valid", 64'(o_valid), 64'(exp_ov));
      check("pkt_ready", 64'(pkt_ready), 64'((kind == K_DATA) && rdy));
      check("selects", 64'({pad_pkt, zero_pkt, mgln_pkt}),
            64'({kind == K_PAD, kind == K_ZERO, kind == K_LEN}));
      check("msg_len", msg_len, 64'((kind == K_DATA) ? pos : n) * 64);
      @(posedge clk);
      #1;
      check("blk_done", 64'(blk_done), 64'(xfer && (pos % BW == BW - 1)));
      check("msg_done", 64'(msg_done), 64'(xfer && kind == K_LEN));
      nblk += int'(blk_done);
      nmsg += int'(msg_done);
      if (xfer) pos++;
      @(negedge clk);
    end
    if (stop_at < 0) begin
      check("blk_count", 64'(nblk), 64'(tw / BW));
      check("msg_count", 64'(nmsg), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; pkt_valid = 1'b1; pkt_last = 1'b1; o_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_pkt_ready", 64'(pkt_ready), 64'd0);
    check("rst_selects", 64'({pad_pkt, zero_pkt, mgln_pkt}), 64'd0);
    check("rst_msg_len", msg_len, 64'd0);
    check("rst_pulses", 64'({blk_done, msg_done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_msg(1, 0, -1);    // pad idx1, 13 zeros, length 64
    run_msg(14, 0, -1);   // pad idx14, no zeros, length 896
    run_msg(15, 0, -1);   // pad wraps to a second block, length 960
    run_msg(3, 2, -1);    // stalls during zero words, length 192

    // Reset while ZERO words are being emitted.
    run_msg(3, 0, 6);
    #1;
    check("pre_rst_zero", 64'(zero_pkt), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_selects", 64'({pad_pkt, zero_pkt, mgln_pkt}), 64'd0);
    check("mid_rst_msg_len", msg_len, 64'd0);
    check("mid_rst_o_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_msg(1, 0, -1);

    // Back-to-back messages with no idle cycle between them.
    run_msg(2, 0, -1);
    run_msg(17, 0, -1);

    // Randomized lengths and handshakes.
    for (int i = 0; i < 12; i++) run_msg(int'($urandom_range(1, 40)), 1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
